byte_ram: RTL and testbench

- Byte-addressable data memory for the SoC load/store path.
- Supports byte, halfword and word accesses, little-endian, with sign or zero extension on loads.
- Has a valid/ready request/response handshake with one-cycle registered read latency, and flags out-of-range, misaligned and reserved-size accesses as exceptions.
- Sits between the core's memory stage and the bus; generalises the earlier single-byte combinational RAM.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/ram_bank.sv | 48 ++++
 rtl/byte_ram.sv | 172 +++++++++++++++++
 tb/tb_byte_ram.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable data memory.
//   - access-size encodings carried on the len port
//   - response FSM state encoding
//   - lane_mask(): byte-lane write enables for an access size and address offset
package mem_pkg;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;
    localparam logic [1:0] LEN_R = 2'b11;  // reserved, always raises an exception

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // One enable bit per byte lane (bit n = byte at addr offset n).
    // The halfword upper-lane choice only looks at off[1], so the result
    // is meaningful only for aligned accesses, which the exception logic enforces.
    function automatic logic [3:0] lane_mask(input logic [1:0] len, input logic [1:0] off);
        logic [3:0] mask;
        case (len)
            LEN_B:   mask = 4'b0001 << off;
            LEN_H:   mask = off[1] ? 4'b1100 : 4'b0011;
            LEN_W:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One byte-wide storage bank.
//   clk    : rising-edge clock
//   we     : write enable, data written at the rising edge
//   addr   : row index
//   wdata  : byte to write
//   rdata  : current contents of the addressed row (sampled by the parent's
//            response register, so the overall read path is synchronous)
// Contents are never reset; init_zero only sets the elaboration-time value.
module ram_bank #(
    parameter int depth_w   = 8,
    parameter bit init_zero = 1'b0
) (
    input  logic               clk,
    input  logic               we,
    input  logic [depth_w-1:0] addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata
);

    localparam int DEPTH = 1 << depth_w;

    generate
        if (init_zero) begin : g_zero
            logic [7:0] mem_r [0:DEPTH-1] = '{default: 8'h00};

            // Byte write at the clock edge
            always_ff @(posedge clk) begin
                if (we) begin
                    mem_r[addr] <= wdata;
                end
            end

            assign rdata = mem_r[addr];
        end else begin : g_plain
            logic [7:0] mem_r [0:DEPTH-1];

            // Byte write at the clock edge
            always_ff @(posedge clk) begin
                if (we) begin
                    mem_r[addr] <= wdata;
                end
            end

            assign rdata = mem_r[addr];
        end
    endgenerate

endmodule

// File: rtl/byte_ram.sv
// Byte-addressable data memory for the load/store path.
// Little-endian byte/half/word accesses, sign/zero-extended loads, a
// valid/ready request/response handshake with one cycle of read latency,
// and exception flagging for out-of-range, misaligned and reserved accesses.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready : request handshake
//   rw                    : 1 = store, 0 = load
//   len                   : 00 byte, 01 half, 10 word, 11 reserved
//   unsigned_ld           : 1 = zero-extend load result
//   addr, write           : byte address, store data (low bytes used)
//   resp_valid/resp_ready : response handshake
//   read, exception       : registered response payload
module byte_ram
    import mem_pkg::*;
#(
    parameter int ram_width = 10,
    parameter bit init_zero = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        rw,
    input  logic [1:0]  len,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] write,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] read,
    output logic        exception
);

    localparam int ROW_W = ram_width - 2;

    state_t             state_r;
    logic [31:0]        read_r;
    logic               exc_r;

    logic               accept_s;
    logic               exc_s;
    logic [3:0]         we_s;
    logic [ROW_W-1:0]   row_s;
    logic [3:0][7:0]    wdata_s;
    logic [3:0][7:0]    lane_s;
    logic [31:0]        load_s;
    logic [31:0]        resp_data_s;

    // A new request can be taken whenever the response slot is empty or draining
    assign req_ready  = (state_r == ST_IDLE) | ((state_r == ST_RESP) & resp_ready);
    assign accept_s   = req_valid & req_ready;
    assign resp_valid = (state_r == ST_RESP);
    assign read       = read_r;
    assign exception  = exc_r;

    // Exception decode: out of range, reserved size, misaligned half/word
    always_comb begin
        exc_s = 1'b0;
        if (addr[31:ram_width] != '0) begin
            exc_s = 1'b1;
        end else begin
            case (len)
                LEN_B:   exc_s = 1'b0;
                LEN_H:   exc_s = addr[0];
                LEN_W:   exc_s = (addr[1:0] != 2'b00);
                default: exc_s = 1'b1;
            endcase
        end
    end

    // Row index only after range check; out-of-range accesses never write
    assign row_s = addr[ram_width-1:2];
    assign we_s  = (accept_s & rw & ~exc_s) ? lane_mask(len, addr[1:0]) : 4'b0000;

    // Steer store bytes onto the lanes they land in
    always_comb begin
        wdata_s = '0;
        for (int n = 0; n < 4; n++) begin
            case (len)
                LEN_B:   wdata_s[n] = write[7:0];
                LEN_H:   wdata_s[n] = n[0] ? write[15:8] : write[7:0];
                LEN_W:   wdata_s[n] = write[8*n +: 8];
                default: wdata_s[n] = 8'h00;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_bank
            ram_bank #(
                .depth_w   (ROW_W),
                .init_zero (init_zero)
            ) u_bank (
                .clk   (clk),
                .we    (we_s[g]),
                .addr  (row_s),
                .wdata (wdata_s[g]),
                .rdata (lane_s[g])
            );
        end
    endgenerate

    // Right-justify and extend the addressed bytes of the row
    always_comb begin
        load_s = 32'h0000_0000;
        case (len)
            LEN_B: begin
                if (unsigned_ld) begin
                    load_s = {24'h00_0000, lane_s[addr[1:0]]};
                end else begin
                    load_s = {{24{lane_s[addr[1:0]][7]}}, lane_s[addr[1:0]]};
                end
            end
            LEN_H: begin
                if (unsigned_ld) begin
                    load_s = {16'h0000, lane_s[{addr[1], 1'b1}], lane_s[{addr[1], 1'b0}]};
                end else begin
                    load_s = {{16{lane_s[{addr[1], 1'b1}][7]}},
                              lane_s[{addr[1], 1'b1}], lane_s[{addr[1], 1'b0}]};
                end
            end
            LEN_W:   load_s = lane_s;
            default: load_s = 32'h0000_0000;
        endcase
    end

    // Stores and faulting accesses answer with zero data
    always_comb begin
        if (rw | exc_s) begin
            resp_data_s = 32'h0000_0000;
        end else begin
            resp_data_s = load_s;
        end
    end

    // Response FSM with registered payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            read_r  <= 32'h0000_0000;
            exc_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_RESP;
                        read_r  <= resp_data_s;
                        exc_r   <= exc_s;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        if (accept_s) begin
                            read_r <= resp_data_s;
                            exc_r  <= exc_s;
                        end else begin
                            state_r <= ST_IDLE;
                            read_r  <= 32'h0000_0000;
                            exc_r   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    read_r  <= 32'h0000_0000;
                    exc_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_ram.sv
module tb_byte_ram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        rw = 1'b0;
    logic [1:0]  len = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] write = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] read;
    logic        exception;

    int n_checks = 0;
    int n_errors = 0;

    byte_ram #(.ram_width(10), .init_zero(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .rw          (rw),
        .len         (len),
        .unsigned_ld (unsigned_ld),
        .addr        (addr),
        .write       (write),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .read        (read),
        .exception   (exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request with resp_ready high; checks the response one cycle later
    task automatic access(input string tag, input logic w, input logic [1:0] l,
                          input logic u, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_ex);
        @(negedge clk);
        req_valid = 1'b1; rw = w; len = l; unsigned_ld = u; addr = a; write = d;
        resp_ready = 1'b1;
        check({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, "_vld"}, {31'b0, resp_valid}, 32'd1);
        check({tag, "_rd"},  read, exp_rd);
        check({tag, "_ex"},  {31'b0, exception}, {31'b0, exp_ex});
    endtask

    initial begin
        #12;
        check("rst_vld", {31'b0, resp_valid}, 32'd0);
        check("rst_rd",  read, 32'd0);
        check("rst_ex",  {31'b0, exception}, 32'd0);
        rst_n = 1'b1;

        // Basic store/load, extension
        access("sw10",  1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0);
        access("lw10",  1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0);
        access("lb13",  1'b0, 2'b00, 1'b0, 32'h013, 32'h0, 32'hFFFFFFDE, 1'b0);
        access("lhu10", 1'b0, 2'b01, 1'b1, 32'h010, 32'h0, 32'h0000BEEF, 1'b0);
        access("lh12",  1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 32'hFFFFDEAD, 1'b0);
        access("sb11",  1'b1, 2'b00, 1'b0, 32'h011, 32'hAAAAAA55, 32'h0, 1'b0);
        access("lw10b", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hDEAD55EF, 1'b0);
        access("lbu11", 1'b0, 2'b00, 1'b1, 32'h011, 32'h0, 32'h00000055, 1'b0);

        // Exceptions on loads
        access("lw02",  1'b0, 2'b10, 1'b0, 32'h002, 32'h0, 32'h0, 1'b1);
        access("lh01",  1'b0, 2'b01, 1'b0, 32'h001, 32'h0, 32'h0, 1'b1);
        access("lr10",  1'b0, 2'b11, 1'b0, 32'h010, 32'h0, 32'h0, 1'b1);
        access("lw400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
        // Exceptions on stores must not touch memory
        access("sw12",  1'b1, 2'b10, 1'b0, 32'h012, 32'h12345678, 32'h0, 1'b1);
        access("sh11",  1'b1, 2'b01, 1'b0, 32'h011, 32'h12345678, 32'h0, 1'b1);
        access("sr10",  1'b1, 2'b11, 1'b0, 32'h010, 32'h12345678, 32'h0, 1'b1);
        access("sw410", 1'b1, 2'b10, 1'b0, 32'h410, 32'h12345678, 32'h0, 1'b1);
        access("lw10c", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hDEAD55EF, 1'b0);

        // Back-to-back loads under backpressure
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; rw = 1'b0; len = 2'b10; unsigned_ld = 1'b0; addr = 32'h010;
        @(posedge clk); #1;
        len = 2'b00; unsigned_ld = 1'b1; addr = 32'h013;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rdy", {31'b0, req_ready}, 32'd0);
            check("bp_vld", {31'b0, resp_valid}, 32'd1);
            check("bp_rd",  read, 32'hDEAD55EF);
            check("bp_ex",  {31'b0, exception}, 32'd0);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_rdy2", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp2_vld", {31'b0, resp_valid}, 32'd1);
        check("bp2_rd",  read, 32'h000000DE);
        @(posedge clk); #1;
        check("bp_idle", {31'b0, resp_valid}, 32'd0);

        // Reset with a pending exception response
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; rw = 1'b0; len = 2'b11; addr = 32'h010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_vld", {31'b0, resp_valid}, 32'd1);
        check("pre_ex",  {31'b0, exception}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_vld", {31'b0, resp_valid}, 32'd0);
        check("mr_rd",  read, 32'd0);
        check("mr_ex",  {31'b0, exception}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_vld", {31'b0, resp_valid}, 32'd0);
        access("lw10d", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hDEAD55EF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
